// File: rtl/mult_div_unit.sv
// Sequential 32-bit HI/LO multiply/divide unit: MULTU/MULT/DIVU/DIV over 32 iteration cycles,
// magnitudes only in the datapath, with the result sign applied in a dedicated fix-up cycle.
module mult_div_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] operand_a,
    input  logic [31:0] operand_b,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        div_by_zero
);

    // state    | meaning
    // IDLE     | waiting for start, operands captured on start
    // CALC     | 32 shift-add / shift-subtract iterations
    // SIGN_FIX | apply result signs, write HI/LO and div_by_zero
    // DONE     | one-cycle completion pulse
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_CALC     = 2'd1,
        ST_SIGN_FIX = 2'd2,
        ST_DONE     = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        is_div_q, is_div_d;
    logic        neg_lo_q, neg_lo_d;
    logic        neg_hi_q, neg_hi_d;
    logic        b_zero_q, b_zero_d;
    logic [31:0] opnd_q, opnd_d;
    logic [31:0] a_raw_q, a_raw_d;
    logic [63:0] acc_q, acc_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        dbz_q, dbz_d;

    logic        is_signed;
    logic [31:0] a_mag, b_mag;
    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    logic [32:0] div_rem;
    logic [32:0] div_diff;
    logic [63:0] div_next;
    logic [63:0] prod_neg;
    logic [31:0] quot_fix, rem_fix;

    assign is_signed = op[0];
    assign a_mag     = (is_signed && operand_a[31]) ? (32'd0 - operand_a) : operand_a;
    assign b_mag     = (is_signed && operand_b[31]) ? (32'd0 - operand_b) : operand_b;

    // Multiply: multiplier sits in acc[31:0] and shifts out LSB-first while the product grows in from the top.
    assign mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
    assign mul_next = {mul_sum, acc_q[31:1]};

    // Divide: partial remainder in acc[63:32], dividend bits shift in while quotient bits fill acc[31:0].
    assign div_rem  = {acc_q[63:32], acc_q[31]};
    assign div_diff = div_rem - {1'b0, opnd_q};
    assign div_next = div_diff[32] ? {div_rem[31:0], acc_q[30:0], 1'b0}
                                   : {div_diff[31:0], acc_q[30:0], 1'b1};

    assign prod_neg = 64'd0 - acc_q;
    assign quot_fix = neg_lo_q ? (32'd0 - acc_q[31:0])  : acc_q[31:0];
    assign rem_fix  = neg_hi_q ? (32'd0 - acc_q[63:32]) : acc_q[63:32];

    always_comb begin
        state_d  = state_q;
        is_div_d = is_div_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        b_zero_d = b_zero_q;
        opnd_d   = opnd_q;
        a_raw_d  = a_raw_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        dbz_d    = dbz_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    is_div_d = op[1];
                    neg_lo_d = is_signed & (operand_a[31] ^ operand_b[31]);
                    neg_hi_d = is_signed & (op[1] ? operand_a[31]
                                                  : (operand_a[31] ^ operand_b[31]));
                    b_zero_d = (operand_b == 32'd0);
                    a_raw_d  = operand_a;
                    if (op[1]) begin
                        opnd_d = b_mag;
                        acc_d  = {32'd0, a_mag};
                    end else begin
                        opnd_d = a_mag;
                        acc_d  = {32'd0, b_mag};
                    end
                    cnt_d   = 5'd0;
                    state_d = ST_CALC;
                end
            end
            ST_CALC: begin
                acc_d = is_div_q ? div_next : mul_next;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = ST_SIGN_FIX;
                end
            end
            ST_SIGN_FIX: begin
                if (!is_div_q) begin
                    hi_d  = neg_lo_q ? prod_neg[63:32] : acc_q[63:32];
                    lo_d  = neg_lo_q ? prod_neg[31:0]  : acc_q[31:0];
                    dbz_d = 1'b0;
                end else if (b_zero_q) begin
                    hi_d  = a_raw_q;
                    lo_d  = 32'hFFFF_FFFF;
                    dbz_d = 1'b1;
                end else begin
                    hi_d  = rem_fix;
                    lo_d  = quot_fix;
                    dbz_d = 1'b0;
                end
                state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            is_div_q <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            b_zero_q <= 1'b0;
            opnd_q   <= 32'd0;
            a_raw_q  <= 32'd0;
            acc_q    <= 64'd0;
            cnt_q    <= 5'd0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            is_div_q <= is_div_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            b_zero_q <= b_zero_d;
            opnd_q   <= opnd_d;
            a_raw_q  <= a_raw_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            dbz_q    <= dbz_d;
        end
    end

    assign busy        = (state_q != ST_IDLE);
    assign done        = (state_q == ST_DONE);
    assign hi          = hi_q;
    assign lo          = lo_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: a behavioural model pushes expected HI/LO/div_by_zero
// at each start and the entry is popped and compared on the done pulse.
module tb_mult_div_unit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div_by_zero;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
    } exp_t;

    exp_t sb_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    mult_div_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .op          (op),
        .operand_a   (operand_a),
        .operand_b   (operand_b),
        .busy        (busy),
        .done        (done),
        .hi          (hi),
        .lo          (lo),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        longint      sa, sb, q, r;
        logic [63:0] p;
        sa    = longint'($signed(a));
        sb    = longint'($signed(b));
        e.dbz = 1'b0;
        case (o)
            2'b00: begin
                p    = {32'd0, a} * {32'd0, b};
                e.hi = p[63:32];
                e.lo = p[31:0];
            end
            2'b01: begin
                p    = 64'(sa * sb);
                e.hi = p[63:32];
                e.lo = p[31:0];
            end
            default: begin
                if (b == 32'd0) begin
                    e.hi  = a;
                    e.lo  = 32'hFFFF_FFFF;
                    e.dbz = 1'b1;
                end else if (o == 2'b10) begin
                    e.lo = a / b;
                    e.hi = a % b;
                end else begin
                    q    = sa / sb;
                    r    = sa % sb;
                    p    = 64'(q);
                    e.lo = p[31:0];
                    p    = 64'(r);
                    e.hi = p[31:0];
                end
            end
        endcase
        return e;
    endfunction

    // Runs one operation; with interfere set, a DIV start with new operands is pulsed at busy cycle 5.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input bit interfere);
        int   n_busy;
        int   done_at;
        int   n_done;
        exp_t e;
        @(negedge clk);
        start     = 1'b1;
        op        = o;
        operand_a = a;
        operand_b = b;
        sb_q.push_back(model(o, a, b));
        @(posedge clk);
        @(negedge clk);
        start   = 1'b0;
        n_busy  = 0;
        done_at = 0;
        n_done  = 0;
        while (busy && n_busy < 100) begin
            n_busy++;
            if (done) begin
                n_done++;
                if (done_at == 0) done_at = n_busy;
                if (sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    chk({tag, ".hi"}, hi, e.hi);
                    chk({tag, ".lo"}, lo, e.lo);
                    chk({tag, ".dbz"}, 32'(div_by_zero), 32'(e.dbz));
                end
            end
            if (interfere && n_busy == 5) begin
                start     = 1'b1;
                op        = 2'b11;
                operand_a = 32'h0000_DEAD;
                operand_b = 32'd0;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        chk({tag, ".busy_cycles"}, 32'(n_busy), 32'd34);
        chk({tag, ".done_cycle"}, 32'(done_at), 32'd34);
        chk({tag, ".done_count"}, 32'(n_done), 32'd1);
    endtask

    initial begin
        int n_done_rst;
        logic [1:0]  ro;
        logic [31:0] ra, rb;

        rst_n     = 1'b0;
        start     = 1'b0;
        op        = 2'b00;
        operand_a = 32'd0;
        operand_b = 32'd0;
        repeat (3) @(negedge clk);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.done", 32'(done), 32'd0);
        chk("rst.hi", hi, 32'd0);
        chk("rst.lo", lo, 32'd0);
        chk("rst.dbz", 32'(div_by_zero), 32'd0);
        rst_n = 1'b1;

        run_op("multu_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_op("mult_neg", 2'b01, 32'hFFFF_FFFD, 32'd5, 1'b0);
        run_op("div_neg", 2'b11, 32'hFFFF_FFF9, 32'd2, 1'b0);
        run_op("divu_100_7", 2'b10, 32'd100, 32'd7, 1'b0);
        run_op("divu_zero", 2'b10, 32'd100, 32'd0, 1'b0);
        run_op("multu_2_3", 2'b00, 32'd2, 32'd3, 1'b0);
        run_op("div_ovf", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op("div_zero_s", 2'b11, 32'hFFFF_FF9C, 32'd0, 1'b0);
        run_op("div_negrem", 2'b11, 32'd7, 32'hFFFF_FFFE, 1'b0);
        run_op("ignore_start", 2'b00, 32'd6, 32'd7, 1'b1);

        for (int i = 0; i < 10; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            if (ro[1] && $urandom_range(0, 3) == 0) rb = 32'd0;
            if (ro[1] && $urandom_range(0, 2) == 0) rb = rb >> $urandom_range(8, 28);
            run_op("random", ro, ra, rb, 1'b0);
        end

        // Abort a DIVU mid-flight with HI/LO holding the previous product.
        @(negedge clk);
        start     = 1'b1;
        op        = 2'b10;
        operand_a = 32'd1000;
        operand_b = 32'd3;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        chk("pre_abort.busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort.busy", 32'(busy), 32'd0);
        chk("abort.hi", hi, 32'd0);
        chk("abort.lo", lo, 32'd0);
        n_done_rst = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (i == 2) rst_n = 1'b1;
            if (done) n_done_rst++;
        end
        chk("abort.no_done", 32'(n_done_rst), 32'd0);
        chk("abort.hi_hold", hi, 32'd0);
        run_op("after_reset", 2'b10, 32'd1000, 32'd3, 1'b0);

        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
